// File: rtl/ju_bp.sv
// Execute-stage jump/branch unit with a 2-bit saturating-counter BHT for fetch prediction.
// Results, illegal flag and mispredict redirect are registered; hold freezes all state.
module ju_bp #(
   parameter int XLEN      = 32,
   parameter int IMM_W     = 13,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  f_pc,
   output logic             f_pred_taken,
   input  logic             ex_valid,
   input  logic             ex_kill,
   input  logic             hold,
   input  logic [1:0]       ju_c,
   input  logic [2:0]       mem_op,
   input  logic [XLEN-1:0]  pc_addr,
   input  logic [XLEN-1:0]  alu_out,
   input  logic [IMM_W-1:0] im_in,
   input  logic             ex_pred_taken,
   output logic [XLEN-1:0]  ju_out,
   output logic [1:0]       pc_c,
   output logic [IMM_W-1:0] b_im_out,
   output logic             wb_valid,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             illegal,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [1:0]       r_bht [BHT_DEPTH];
   logic [XLEN-1:0]  r_ju_out;
   logic [1:0]       r_pc_c;
   logic [IMM_W-1:0] r_b_im_out;
   logic             r_wb_valid;
   logic             r_redirect;
   logic [XLEN-1:0]  r_redirect_pc;
   logic             r_illegal;
   logic [CNT_W-1:0] r_mispred_cnt;

   logic [IDX_W-1:0] w_f_idx;
   logic [IDX_W-1:0] w_ex_idx;
   logic             w_accept;
   logic             w_is_br;
   logic             w_br_illegal;
   logic             w_legal_br;
   logic             w_cond;
   logic             w_taken;
   logic             w_mispred;
   logic [XLEN-1:0]  w_pc_plus4;
   logic [XLEN-1:0]  w_br_tgt;
   logic [1:0]       w_ctr_old;
   logic [1:0]       w_ctr_new;
   logic [XLEN-1:0]  w_ju_out_next;
   logic [1:0]       w_pc_c_next;
   logic [IMM_W-1:0] w_b_im_next;
   logic             w_illegal_next;
   logic [XLEN-1:0]  w_redirect_pc_next;

   assign w_f_idx      = f_pc[IDX_W+1:2];
   assign w_ex_idx     = pc_addr[IDX_W+1:2];
   assign f_pred_taken = r_bht[w_f_idx][1];

   assign w_accept     = ex_valid & ~ex_kill & ~hold;
   assign w_is_br      = (ju_c == 2'd1);
   assign w_br_illegal = w_is_br & (mem_op[2:1] == 2'b01);
   assign w_legal_br   = w_is_br & ~w_br_illegal;
   assign w_pc_plus4   = pc_addr + XLEN'(4);
   assign w_br_tgt     = pc_addr + {{(XLEN-IMM_W){im_in[IMM_W-1]}}, im_in};
   assign w_taken      = w_legal_br & w_cond;
   assign w_mispred    = w_legal_br & (w_taken != ex_pred_taken);
   assign w_ctr_old    = r_bht[w_ex_idx];

   always_comb begin
      w_cond = 1'b0;
      case (mem_op)
         3'd0:    w_cond = (alu_out == '0);
         3'd1:    w_cond = (alu_out != '0);
         3'd2,
         3'd3:    w_cond = 1'b0;
         default: w_cond = alu_out[0];
      endcase
   end

   // Saturating 2-bit counter step toward the resolved direction.
   always_comb begin
      w_ctr_new = w_ctr_old;
      if (w_taken) begin
         if (w_ctr_old != 2'b11) w_ctr_new = w_ctr_old + 2'b01;
      end else begin
         if (w_ctr_old != 2'b00) w_ctr_new = w_ctr_old - 2'b01;
      end
   end

   always_comb begin
      w_ju_out_next      = '0;
      w_pc_c_next        = 2'd0;
      w_b_im_next        = '0;
      w_illegal_next     = 1'b0;
      w_redirect_pc_next = '0;
      case (ju_c)
         2'd0: w_ju_out_next = alu_out;
         2'd1: begin
            w_illegal_next = w_br_illegal;
            if (w_taken) begin
               w_pc_c_next = 2'd2;
               w_b_im_next = im_in;
            end
         end
         2'd2: w_ju_out_next = w_pc_plus4;
         default: w_illegal_next = 1'b1;
      endcase
      if (w_mispred) w_redirect_pc_next = w_taken ? w_br_tgt : w_pc_plus4;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ju_out      <= '0;
         r_pc_c        <= 2'd0;
         r_b_im_out    <= '0;
         r_wb_valid    <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_illegal     <= 1'b0;
         r_mispred_cnt <= '0;
      end else if (!hold) begin
         if (w_accept) begin
            r_ju_out      <= w_ju_out_next;
            r_pc_c        <= w_pc_c_next;
            r_b_im_out    <= w_b_im_next;
            r_wb_valid    <= 1'b1;
            r_redirect    <= w_mispred;
            r_redirect_pc <= w_redirect_pc_next;
            r_illegal     <= w_illegal_next;
            if (w_mispred) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
         end else begin
            r_ju_out      <= '0;
            r_pc_c        <= 2'd0;
            r_b_im_out    <= '0;
            r_wb_valid    <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_illegal     <= 1'b0;
         end
      end
   end

   // Every counter restarts weakly not-taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
      end else if (w_accept && w_legal_br) begin
         r_bht[w_ex_idx] <= w_ctr_new;
      end
   end

   assign ju_out      = r_ju_out;
   assign pc_c        = r_pc_c;
   assign b_im_out    = r_b_im_out;
   assign wb_valid    = r_wb_valid;
   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign illegal     = r_illegal;
   assign mispred_cnt = r_mispred_cnt;

endmodule

// File: doc/ju_bp.md
# ju_bp

Parametrised successor to the execute-stage jump/branch unit: resolves conditional branches and jumps from the ALU result, adds a direct-mapped branch history table (BHT) of 2-bit saturating counters for fetch-time prediction, and produces a registered mispredict redirect. Sits between the ALU and the PC/fetch logic. It keeps the legacy `ju_out`/`pc_c`/`b_im_out` result encoding, now registered, and adds prediction, redirect, hold/kill and a mispredict counter.

## Interface
- XLEN, 32, datapath width
- IMM_W, 13, branch offset width (byte offset, sign-extended)
- BHT_DEPTH, 64, BHT entries; power of two, ≥2
- CNT_W, 16, mispredict counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- f_pc  in  XLEN  fetch PC for prediction lookup
- f_pred_taken  out  1  combinational prediction for f_pc (counter MSB)
- ex_valid  in  1  execute-stage instruction valid
- ex_kill  in  1  squash the current ex instruction (higher-priority flush)
- hold  in  1  pipeline stall; freezes all registers
- ju_c  in  2  0 = pass ALU, 1 = conditional branch, 2 = jal/jalr link, 3 = reserved
- mem_op  in  3  branch funct3
- pc_addr  in  XLEN  PC of ex instruction
- alu_out  in  XLEN  ALU result (compare result for branches)
- im_in  in  IMM_W  branch offset
- ex_pred_taken  in  1  prediction carried down from fetch for this instruction
- ju_out  out  XLEN  registered result
- pc_c  out  2  registered PC control: 2 = branch taken, else 0
- b_im_out  out  IMM_W  registered offset (im_in when taken, else 0)
- wb_valid  out  1  registered valid for ju_out
- redirect  out  1  one-cycle mispredict pulse
- redirect_pc  out  XLEN  corrected fetch target
- illegal  out  1  registered flag: branch with mem_op 2 or 3, or ju_c 3
- mispred_cnt  out  CNT_W  mispredict count, wraps

## Operation
- Instruction accepted in a cycle when ex_valid=1, ex_kill=0 and hold=0. A non-accepted cycle registers wb_valid=0, redirect=0, illegal=0, ju_out=0, pc_c=0 and b_im_out=0, unless hold=1, in which case all registers keep their values.
- Branch condition (ju_c=1) by mem_op:
  - 0: taken iff alu_out==0.
  - 1: taken iff alu_out!=0.
  - 4/5/6/7: taken iff alu_out[0]=1.
  - 2/3: not taken, illegal=1, no BHT update, no redirect.
- Result encoding:
  - ju_c=0: ju_out=alu_out.
  - ju_c=1: ju_out=0; pc_c=2 and b_im_out=im_in if taken, else pc_c=0 and b_im_out=0.
  - ju_c=2: ju_out=pc_addr+4 (mod 2^XLEN); pc_c=0.
  - ju_c=3: all result outputs 0, illegal=1.
- Mispredict (legal branch only):
  - actual taken, predicted not taken: redirect=1, redirect_pc=pc_addr+sext(im_in).
  - actual not taken, predicted taken: redirect=1, redirect_pc=pc_addr+4.
  - Correct prediction: redirect=0, redirect_pc=0.
- mispred_cnt increments by 1 per redirect and wraps from all-ones to 0.
- BHT index is pc[log2(BHT_DEPTH)+1:2]; there are no tags, so aliasing is permitted.
- BHT update on every accepted legal branch: taken → counter+1, saturating at 3; not taken → counter−1, saturating at 0.
- f_pred_taken = bht[idx(f_pc)][1].

## Timing
- Result, redirect and illegal outputs have one-cycle latency: inputs sampled at edge N appear after edge N and are valid for the cycle following it.
- redirect is a single-cycle pulse per mispredicting instruction; back-to-back mispredicts give back-to-back pulses.
- BHT write takes effect at the accepting edge. f_pred_taken is read-before-write: when the same index is written in the same cycle, the lookup returns the old value and the new value is visible from the next cycle.
- Reset (asynchronous, any time, including mid-operation):
  - all outputs 0; mispred_cnt=0.
  - every BHT counter = 2'b01 (weakly not taken), so f_pred_taken=0.
- Reset release is synchronous to clk; the first accepted instruction is the one sampled at the first edge with rst=0.
- hold has priority over ex_valid. ex_kill has priority over ex_valid but not over hold: hold=1 with ex_kill=1 freezes all registers.

## Test plan
- Reset: assert rst mid-stream after 3 branches → all outputs 0, mispred_cnt=0, f_pred_taken=0 for every PC.
- BEQ with alu_out=0, pc_addr=0x100, im_in=0x010, ex_pred_taken=0 → next cycle pc_c=2, b_im_out=0x010, redirect=1, redirect_pc=0x110, mispred_cnt=1.
- BHT saturation: 4 taken branches at PC 0x40 → f_pred_taken(0x40)=1 after the 1st; one not-taken → still 1; three more not-taken → 0. Alias check: PC 0x140 with BHT_DEPTH=64 shares the entry.
- Predicted-taken BNE with alu_out=0 at 0x200 → redirect=1, redirect_pc=0x204, pc_c=0.
- jal at pc_addr=0xFFFFFFFC → ju_out=0x00000000, redirect=0; illegal mem_op=2 → illegal=1, no BHT change.
- hold=1 for 2 cycles with new inputs, and ex_kill on a mispredicting branch → outputs unchanged during hold; killed branch gives no redirect, no BHT or counter change; mispred_cnt wraps to 0 after 2^CNT_W redirects.
